// File: rtl/fifo_rd_stream_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_if
//   Valid/ready stream bundle carrying words out of the FIFO read adapter.
//
//   Signals:
//     data   width  stream word, driven by the producer
//     valid  1      producer holds a word on data
//     ready  1      consumer accepts the word at the next clock edge
//
//   Modports:
//     master  producer side (drives data/valid, samples ready)
//     slave   consumer side (samples data/valid, drives ready)
// ---------------------------------------------------------------------------
interface fifo_rd_stream_if #(
  parameter int width = 9
);

  logic [width-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side adapter for a dual-clock FIFO running in standard (non
//   first-word-fall-through) mode with a registered output. It issues
//   fifo_rd_en whenever the FIFO has data and there is guaranteed room for
//   the returning word, captures fifo_dout LAT cycles after each read into a
//   small skid buffer, and presents the buffered words as a valid/ready
//   stream with full throughput and strict in-order delivery.
//   Everything lives in the FIFO read clock domain.
//
//   Parameters:
//     width  data width, must match the FIFO instance
//     LAT    FIFO read latency (rd_en sampled -> dout valid), 1..3
//     DEPTH  skid buffer entries, fixed at LAT+2 (derived, not overridable)
//
//   Ports:
//     clk         read-side clock (same as the FIFO rclk)
//     rst         asynchronous active-high reset (same net as the FIFO rst)
//     fifo_dout   FIFO read data
//     fifo_empty  FIFO empty flag
//     fifo_rd_en  FIFO read enable
//     flush       one-cycle synchronous discard of buffered/in-flight words
//     m           stream output (master modport: data, valid, ready)
//     level       number of words currently held in the skid buffer
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter  int width = 9,
  parameter  int LAT   = 1,
  localparam int DEPTH = LAT + 2,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int SUM_W = LVL_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [width-1:0]  fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              flush,
  fifo_rd_stream_if.master  m,
  output logic [LVL_W-1:0]  level
);

  // Skid buffer storage and bookkeeping
  logic [width-1:0] buf_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] cnt;

  // One bit per outstanding read: bit 0 is set the cycle after a read is
  // issued, bit LAT-1 marks the cycle in which that read's data is on
  // fifo_dout.
  logic [LAT-1:0]   inf;

  logic             capture;
  logic             pop;
  logic [SUM_W-1:0] inflight_n;
  logic [SUM_W-1:0] committed;

  // Pointer advance with an explicit wrap so that non-power-of-two depths
  // never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Count how many reads are still travelling through the FIFO output
  // pipeline. Together with cnt this is every slot already promised away.
  always_comb begin
    inflight_n = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_n = inflight_n + SUM_W'(inf[i]);
    end
  end

  assign committed = SUM_W'(cnt) + inflight_n;
  assign capture   = inf[LAT-1];
  assign pop       = m.valid && m.ready;

  // Read issue. Only registered state, fifo_empty, flush and the reset pin
  // feed this, so downstream ready never reaches the FIFO in the same cycle.
  // Reserving a slot for every in-flight word is what makes overflow
  // impossible, and gating on rst drops the enable as soon as reset
  // asserts, without waiting for an edge.
  always_comb begin
    fifo_rd_en = !rst && !flush && !fifo_empty && (committed < SUM_W'(DEPTH));
  end

  // Stream side: the head of the buffer is presented directly, so data and
  // valid can only change on a pop or a capture into an empty buffer.
  assign m.valid = (cnt != '0);
  assign m.data  = buf_mem[rd_ptr];
  assign level   = cnt;

  // Buffer state. Flush wipes the bookkeeping and the in-flight bits, which
  // is what drops the words that are still on their way back from the FIFO;
  // the stored data itself is left alone since nothing can read it until
  // it is overwritten. A simultaneous capture and pop moves both pointers
  // and leaves cnt unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      inf    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      inf    <= '0;
    end else begin
      inf <= LAT'({inf, fifo_rd_en});
      if (capture) begin
        buf_mem[wr_ptr] <= fifo_dout;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({capture, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A capture into a full buffer with no pop in the same cycle would lose a
  // word; the issue rule is meant to make this unreachable.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst)
      !(capture && (cnt == LVL_W'(DEPTH)) && !pop)
  );

endmodule
